// File: rtl/baccarat_round_ctrl_if.sv
// Signal bundle between the baccarat round controller (slave) and the
// sequencer/datapath side that feeds it scores and consumes its strobes (master).
interface baccarat_round_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             step;
  logic             new_round;
  logic [3:0]       pscore;
  logic [3:0]       dscore;
  logic [3:0]       pcard3;
  logic             load_pcard1, load_pcard2, load_pcard3;
  logic             load_dcard1, load_dcard2, load_dcard3;
  logic             clear_hands;
  logic             player_win_light, dealer_win_light;
  logic             round_done;
  logic [CNT_W-1:0] player_wins, dealer_wins, ties, rounds;
  logic             game_over;

  modport master (
    output step, new_round, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  clear_hands, player_win_light, dealer_win_light, round_done,
    input  player_wins, dealer_wins, ties, rounds, game_over
  );

  modport slave (
    input  step, new_round, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output clear_hands, player_win_light, dealer_win_light, round_done,
    output player_wins, dealer_wins, ties, rounds, game_over
  );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat deal/tableau sequencer with step-gated or free-running
// advance, saturating win/tie/round statistics and an optional round limit.
module baccarat_round_ctrl #(
  parameter int CNT_W        = 8,
  parameter bit AUTO_ADVANCE = 1'b0,
  parameter int MAX_ROUNDS   = 0
) (
  input logic                  slow_clock,
  input logic                  reset,
  baccarat_round_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DRAW_P3, BANKER, DRAW_D3, RESULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // A limit the rounds counter can never reach (it saturates first) disables game_over.
  localparam bit               LIMIT_ON  = (MAX_ROUNDS != 0) && ($clog2(MAX_ROUNDS + 1) <= CNT_W);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_ROUNDS);

  state_t state;
  logic   adv;
  logic   live;
  logic   natural;
  logic   to_result;
  logic   leave_result;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] p3);
    case (d)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return p3 != 4'd8;
      4'd4:             return (p3 >= 4'd2) && (p3 <= 4'd7);
      4'd5:             return (p3 >= 4'd4) && (p3 <= 4'd7);
      4'd6:             return (p3 >= 4'd6) && (p3 <= 4'd7);
      default:          return 1'b0;
    endcase
  endfunction

  assign adv  = bus.step | AUTO_ADVANCE;
  assign live = adv & ~reset;

  assign bus.load_pcard1 = live && (state == DEAL_P1);
  assign bus.load_dcard1 = live && (state == DEAL_D1);
  assign bus.load_pcard2 = live && (state == DEAL_P2);
  assign bus.load_dcard2 = live && (state == DEAL_D2);
  assign bus.load_pcard3 = live && (state == DRAW_P3);
  assign bus.load_dcard3 = live && (state == DRAW_D3);

  assign leave_result    = live && (state == RESULT) && bus.new_round && !bus.game_over;
  assign bus.clear_hands = leave_result;

  // Every path into RESULT funnels through one flag so lights and counters update in one place.
  assign natural   = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);
  assign to_result = adv && (
                       ((state == EVAL) && (natural || ((bus.pscore > 4'd5) && (bus.dscore > 4'd5)))) ||
                       ((state == BANKER) && !banker_draws(bus.dscore, bus.pcard3)) ||
                       (state == DRAW_D3));

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state                <= DEAL_P1;
      bus.player_win_light <= 1'b0;
      bus.dealer_win_light <= 1'b0;
      bus.round_done       <= 1'b0;
      bus.player_wins      <= '0;
      bus.dealer_wins      <= '0;
      bus.ties             <= '0;
      bus.rounds           <= '0;
      bus.game_over        <= 1'b0;
    end else begin
      bus.round_done <= 1'b0;
      if (LIMIT_ON && (bus.rounds == LIMIT_CNT))
        bus.game_over <= 1'b1;

      if (to_result) begin
        state                <= RESULT;
        bus.round_done       <= 1'b1;
        bus.player_win_light <= bus.pscore >= bus.dscore;
        bus.dealer_win_light <= bus.dscore >= bus.pscore;
        bus.rounds           <= sat_inc(bus.rounds);
        if (bus.pscore > bus.dscore)
          bus.player_wins <= sat_inc(bus.player_wins);
        else if (bus.dscore > bus.pscore)
          bus.dealer_wins <= sat_inc(bus.dealer_wins);
        else
          bus.ties <= sat_inc(bus.ties);
      end else if (adv) begin
        case (state)
          DEAL_P1: state <= DEAL_D1;
          DEAL_D1: state <= DEAL_P2;
          DEAL_P2: state <= DEAL_D2;
          DEAL_D2: state <= EVAL;
          // No natural and not both standing: player draws on <=5, else dealer draws.
          EVAL:    state <= (bus.pscore <= 4'd5) ? DRAW_P3 : DRAW_D3;
          DRAW_P3: state <= BANKER;
          BANKER:  state <= DRAW_D3;
          RESULT: begin
            if (leave_result) begin
              state                <= DEAL_P1;
              bus.player_win_light <= 1'b0;
              bus.dealer_win_light <= 1'b0;
            end
          end
          default: state <= DEAL_P1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench: free-running controller for tableau paths and reset,
// step-gated controller for gating and saturation, and a round-limited controller.
module tb_baccarat_round_ctrl;

  logic slow_clock;
  logic rst_a, rst_b, rst_c;

  baccarat_round_ctrl_if #(.CNT_W(8)) ia ();
  baccarat_round_ctrl_if #(.CNT_W(2)) ib ();
  baccarat_round_ctrl_if #(.CNT_W(2)) ic ();

  baccarat_round_ctrl #(.CNT_W(8), .AUTO_ADVANCE(1'b1), .MAX_ROUNDS(0)) dut_a (
    .slow_clock(slow_clock), .reset(rst_a), .bus(ia));
  baccarat_round_ctrl #(.CNT_W(2), .AUTO_ADVANCE(1'b0), .MAX_ROUNDS(0)) dut_b (
    .slow_clock(slow_clock), .reset(rst_b), .bus(ib));
  baccarat_round_ctrl #(.CNT_W(2), .AUTO_ADVANCE(1'b1), .MAX_ROUNDS(2)) dut_c (
    .slow_clock(slow_clock), .reset(rst_c), .bus(ic));

  logic [5:0] sa, sb, sc;
  logic [1:0] la, lb, lc;
  assign sa = {ia.load_pcard1, ia.load_dcard1, ia.load_pcard2, ia.load_dcard2, ia.load_pcard3, ia.load_dcard3};
  assign sb = {ib.load_pcard1, ib.load_dcard1, ib.load_pcard2, ib.load_dcard2, ib.load_pcard3, ib.load_dcard3};
  assign sc = {ic.load_pcard1, ic.load_dcard1, ic.load_pcard2, ic.load_dcard2, ic.load_pcard3, ic.load_dcard3};
  assign la = {ia.player_win_light, ia.dealer_win_light};
  assign lb = {ib.player_win_light, ib.dealer_win_light};
  assign lc = {ic.player_win_light, ic.dealer_win_light};

  int checks = 0;
  int errors = 0;

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge slow_clock);
    #2;
  endtask

  task automatic expect_a(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, sa, exp);
    tick();
  endtask

  // Plays one round on dut_a from DEAL_P1; ends sampled in the first RESULT cycle.
  task automatic round_a(input string tag, input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3,
                         input bit dp3, input bit dd3, input logic [1:0] lights,
                         input int pw, input int dw, input int tz, input int rn);
    ia.pscore = p; ia.dscore = d; ia.pcard3 = c3;
    expect_a({tag, "_p1"}, 6'b100000);
    expect_a({tag, "_d1"}, 6'b010000);
    expect_a({tag, "_p2"}, 6'b001000);
    expect_a({tag, "_d2"}, 6'b000100);
    expect_a({tag, "_eval"}, 6'b000000);
    if (dp3) begin
      expect_a({tag, "_p3"}, 6'b000010);
      expect_a({tag, "_banker"}, 6'b000000);
    end
    if (dd3) expect_a({tag, "_d3"}, 6'b000001);
    #1;
    chk({tag, "_res_strobes"}, sa, 6'b000000);
    chk({tag, "_round_done"}, ia.round_done, 1'b1);
    chk({tag, "_lights"}, la, lights);
    chk({tag, "_player_wins"}, ia.player_wins, pw);
    chk({tag, "_dealer_wins"}, ia.dealer_wins, dw);
    chk({tag, "_ties"}, ia.ties, tz);
    chk({tag, "_rounds"}, ia.rounds, rn);
    tick();
  endtask

  task automatic leave_a(input string tag);
    ia.new_round = 1'b1;
    #1;
    chk({tag, "_clear"}, ia.clear_hands, 1'b1);
    tick();
    ia.new_round = 1'b0;
    #1;
    chk({tag, "_lights_clr"}, la, 2'b00);
    chk({tag, "_clear_off"}, ia.clear_hands, 1'b0);
  endtask

  logic [5:0] deal_seq [5] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000000};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.step = 1'b0; ia.new_round = 1'b0; ia.pscore = 4'd9; ia.dscore = 4'd9; ia.pcard3 = 4'd0;
    ib.step = 1'b0; ib.new_round = 1'b0; ib.pscore = 4'd9; ib.dscore = 4'd0; ib.pcard3 = 4'd0;
    ic.step = 1'b0; ic.new_round = 1'b0; ic.pscore = 4'd0; ic.dscore = 4'd9; ic.pcard3 = 4'd0;
    tick();
    tick();

    // Reset state of the free-running controller
    #1;
    chk("rst_strobes", sa, 6'b000000);
    chk("rst_lights", la, 2'b00);
    chk("rst_round_done", ia.round_done, 1'b0);
    chk("rst_rounds", ia.rounds, 0);
    chk("rst_game_over", ia.game_over, 1'b0);
    chk("rst_clear", ia.clear_hands, 1'b0);
    rst_a = 1'b0;
    tick();
    // dut_a dealt P1 on the edge just taken; restart cleanly from DEAL_P1
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;

    // Naturals tie, then third-card tableau paths
    round_a("r1_nat_tie", 4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 2'b11, 0, 0, 1, 1);
    #1;
    chk("r1_rdone_once", ia.round_done, 1'b0);
    chk("r1_hold_lights", la, 2'b11);
    chk("r1_hold_rounds", ia.rounds, 1);
    chk("r1_hold_strobes", sa, 6'b000000);
    tick();
    leave_a("l1");
    round_a("r2_p3_stand", 4'd5, 4'd3, 4'd8, 1'b1, 1'b0, 2'b10, 1, 0, 1, 2);
    leave_a("l2");
    round_a("r3_p3_d3", 4'd5, 4'd3, 4'd7, 1'b1, 1'b1, 2'b10, 2, 0, 1, 3);
    leave_a("l3");
    round_a("r4_d3_only", 4'd6, 4'd5, 4'd0, 1'b0, 1'b1, 2'b10, 3, 0, 1, 4);
    leave_a("l4");
    round_a("r5_stand_tie", 4'd6, 4'd6, 4'd0, 1'b0, 1'b0, 2'b11, 3, 0, 2, 5);
    leave_a("l5");
    round_a("r6_dealer", 4'd2, 4'd7, 4'd0, 1'b1, 1'b0, 2'b01, 3, 1, 2, 6);
    chk("a_game_over_unlimited", ia.game_over, 1'b0);

    // Step-gated controller: one strobe per step pulse, nothing in between
    rst_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ib.step = 1'b1;
      #1;
      chk("b_pulse_strobe", sb, deal_seq[k]);
      tick();
      ib.step = 1'b0;
      #1;
      chk("b_hold1_strobe", sb, 6'b000000);
      chk("b_hold1_rdone", ib.round_done, (k == 4));
      tick();
      #1;
      chk("b_hold2_strobe", sb, 6'b000000);
      chk("b_hold2_rdone", ib.round_done, 1'b0);
      tick();
    end
    chk("b_lights", lb, 2'b10);
    chk("b_wins1", ib.player_wins, 1);
    ib.new_round = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b_newround_nostep", ib.clear_hands, 1'b0);
      chk("b_newround_lights", lb, 2'b10);
      tick();
    end
    ib.step = 1'b1;
    #1;
    chk("b_newround_step", ib.clear_hands, 1'b1);
    tick();
    ib.step = 1'b0;
    ib.new_round = 1'b0;
    #1;
    chk("b_p1_idle", sb, 6'b000000);
    chk("b_lights_clr", lb, 2'b00);
    tick();

    // Saturation: rounds 2..5 all player naturals, step held high
    ib.step = 1'b1;
    for (int r = 2; r <= 5; r++) begin
      repeat (5) tick();
      #1;
      chk("b_sat_rdone", ib.round_done, 1'b1);
      chk("b_sat_wins", ib.player_wins, (r > 3) ? 3 : r);
      chk("b_sat_rounds", ib.rounds, (r > 3) ? 3 : r);
      chk("b_sat_ties", ib.ties, 0);
      tick();
      ib.new_round = (r < 5);
      #1;
      chk("b_sat_clear", ib.clear_hands, (r < 5));
      tick();
      ib.new_round = 1'b0;
    end
    chk("b_sat_dealer", ib.dealer_wins, 0);

    // Round-limited controller
    rst_c = 1'b0;
    repeat (5) tick();
    #1;
    chk("c_r1_rounds", ic.rounds, 1);
    chk("c_r1_go", ic.game_over, 1'b0);
    tick();
    #1;
    chk("c_r1_go_later", ic.game_over, 1'b0);
    ic.new_round = 1'b1;
    #1;
    chk("c_r1_clear", ic.clear_hands, 1'b1);
    tick();
    ic.new_round = 1'b0;
    repeat (4) tick();
    #1;
    chk("c_r2_strobe_eval", sc, 6'b000000);
    tick();
    #1;
    chk("c_r2_rounds", ic.rounds, 2);
    chk("c_r2_dealer", ic.dealer_wins, 2);
    chk("c_r2_lights", lc, 2'b01);
    chk("c_r2_go_same", ic.game_over, 1'b0);
    tick();
    #1;
    chk("c_go_set", ic.game_over, 1'b1);
    ic.new_round = 1'b1;
    #1;
    chk("c_go_no_clear", ic.clear_hands, 1'b0);
    tick();
    #1;
    chk("c_go_stay_strobes", sc, 6'b000000);
    chk("c_go_stay_lights", lc, 2'b01);
    chk("c_go_sticky", ic.game_over, 1'b1);
    chk("c_go_rounds", ic.rounds, 2);
    tick();
    ic.new_round = 1'b0;

    // Reset mid-round in DRAW_P3
    leave_a("l6");
    ia.pscore = 4'd5; ia.dscore = 4'd3; ia.pcard3 = 4'd8;
    for (int k = 0; k < 5; k++) expect_a("rst6_deal", deal_seq[k]);
    rst_a = 1'b1;
    #1;
    chk("rst6_no_strobe", sa, 6'b000000);
    tick();
    rst_a = 1'b0;
    #1;
    chk("rst6_first_p1", sa, 6'b100000);
    chk("rst6_lights", la, 2'b00);
    chk("rst6_pwins", ia.player_wins, 0);
    chk("rst6_dwins", ia.dealer_wins, 0);
    chk("rst6_ties", ia.ties, 0);
    chk("rst6_rounds", ia.rounds, 0);
    chk("rst6_rdone", ia.round_done, 1'b0);
    tick();
    expect_a("rst6_d1", 6'b010000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
